// File: rtl/wb_ic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_ic_pkg
// Description : Shared types and helpers for the Wishbone interconnect blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } wb_arb_state_e;

  // Watchdog counter width; kept at least one bit so a disabled watchdog still elaborates.
  function automatic int wd_cnt_width(input int timeout_cycles);
    return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_if
// Description : Wishbone classic/registered-feedback bus bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic                    err;

  modport master (output adr, cti, bte, dat_w, sel, cyc, stb, we,
                  input  dat_r, ack, err);
  modport slave  (input  adr, cti, bte, dat_w, sel, cyc, stb, we,
                  output dat_r, ack, err);
endinterface
`default_nettype wire

// File: rtl/wb_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_rr2
// Description : Two-way round-robin grant FSM, grant held for whole request.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arb_rr2
  import wb_ic_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_arb_state_e r_state;
  logic          r_last_gnt;
  logic [1:0]    r_gnt;

  // last_gnt resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_gnt      <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if ((req[0] && !req[1]) || (req == 2'b11 && r_last_gnt)) begin
            r_state    <= GNT0;
            r_last_gnt <= 1'b0;
            r_gnt      <= 2'b01;
          end else if (req[1]) begin
            r_state    <= GNT1;
            r_last_gnt <= 1'b1;
            r_gnt      <= 2'b10;
          end
        end
        GNT0: begin
          if (!req[0]) begin
            if (req[1]) begin
              r_state    <= GNT1;
              r_last_gnt <= 1'b1;
              r_gnt      <= 2'b10;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 2'b00;
            end
          end
        end
        GNT1: begin
          if (!req[1]) begin
            if (req[0]) begin
              r_state    <= GNT0;
              r_last_gnt <= 1'b0;
              r_gnt      <= 2'b01;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 2'b00;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
        end
      endcase
    end
  end

  assign gnt = r_gnt;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_2x1
// Description : Two-master to one-slave Wishbone arbiter with response watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_2x1
  import wb_ic_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 0
)(
  input  logic  clk,
  input  logic  rstn,
  wb_if.slave   m0,
  wb_if.slave   m1,
  wb_if.master  s0
);

  localparam int c_SEL_W = WB_DATA_WIDTH / 8;

  logic [1:0]               w_gnt;
  logic [WB_ADDR_WIDTH-1:0] w_adr;
  logic [WB_DATA_WIDTH-1:0] w_dat_w;
  logic [c_SEL_W-1:0]       w_sel;
  logic [2:0]               w_cti;
  logic [1:0]               w_bte;
  logic                     w_we;
  logic                     w_cyc;
  logic                     w_stb;
  logic                     w_wd_err;

  wb_arb_rr2 u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  ({m1.cyc, m0.cyc}),
    .gnt  (w_gnt)
  );

  always_comb begin
    w_adr   = '0;
    w_dat_w = '0;
    w_sel   = '0;
    w_cti   = '0;
    w_bte   = '0;
    w_we    = 1'b0;
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    case (w_gnt)
      2'b01: begin
        w_adr   = m0.adr;
        w_dat_w = m0.dat_w;
        w_sel   = m0.sel;
        w_cti   = m0.cti;
        w_bte   = m0.bte;
        w_we    = m0.we;
        w_cyc   = m0.cyc;
        w_stb   = m0.stb;
      end
      2'b10: begin
        w_adr   = m1.adr;
        w_dat_w = m1.dat_w;
        w_sel   = m1.sel;
        w_cti   = m1.cti;
        w_bte   = m1.bte;
        w_we    = m1.we;
        w_cyc   = m1.cyc;
        w_stb   = m1.stb;
      end
      default: ;
    endcase
  end

  assign s0.adr   = w_adr;
  assign s0.dat_w = w_dat_w;
  assign s0.sel   = w_sel;
  assign s0.cti   = w_cti;
  assign s0.bte   = w_bte;
  assign s0.we    = w_we;
  assign s0.cyc   = w_cyc;
  assign s0.stb   = w_stb;

  assign m0.dat_r = s0.dat_r;
  assign m1.dat_r = s0.dat_r;
  assign m0.ack   = s0.ack && w_gnt[0];
  assign m1.ack   = s0.ack && w_gnt[1];
  assign m0.err   = (s0.err || w_wd_err) && w_gnt[0];
  assign m1.err   = (s0.err || w_wd_err) && w_gnt[1];

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int                c_WD_W    = wd_cnt_width(TIMEOUT_CYCLES);
      localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

      logic [c_WD_W-1:0] r_wd_cnt;
      logic [1:0]        r_gnt_q;
      logic [c_WD_W-1:0] w_cnt_eff;
      logic              w_stall;

      assign w_stall   = w_stb && !s0.ack && !s0.err;
      // A fresh grant must not inherit the previous owner's stall count.
      assign w_cnt_eff = (w_gnt == r_gnt_q) ? r_wd_cnt : '0;
      assign w_wd_err  = w_stall && (w_cnt_eff == c_WD_LAST);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_wd_cnt <= '0;
          r_gnt_q  <= 2'b00;
        end else begin
          r_gnt_q <= w_gnt;
          if (!w_stall || w_wd_err) begin
            r_wd_cnt <= '0;
          end else begin
            r_wd_cnt <= w_cnt_eff + 1'b1;
          end
        end
      end
    end else begin : g_no_wd
      assign w_wd_err = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2x1.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter_2x1
// Description : Self-checking bench for wb_arbiter_2x1 against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_2x1;

  localparam int c_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0_bus ();

  wb_arbiter_2x1 #(
    .WB_ADDR_WIDTH  (32),
    .WB_DATA_WIDTH  (32),
    .TIMEOUT_CYCLES (c_TIMEOUT)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .m0   (m0_bus),
    .m1   (m1_bus),
    .s0   (s0_bus)
  );

  // Stimulus held by the bench for each master and the slave.
  logic        cyc_q [2];
  logic        stb_q [2];
  logic        we_q  [2];
  logic [31:0] adr_q [2];
  logic [31:0] dat_q [2];
  logic [3:0]  sel_q [2];
  logic [2:0]  cti_q [2];
  logic [1:0]  bte_q [2];
  logic        s_ack, s_err;
  logic [31:0] s_dat;

  // Reference model: owner of the bus (-1 none), last served master, stalled-cycle run.
  int own, last, run;
  int n_checks, n_errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    m0_bus.cyc = cyc_q[0]; m0_bus.stb = stb_q[0]; m0_bus.we = we_q[0];
    m0_bus.adr = adr_q[0]; m0_bus.dat_w = dat_q[0]; m0_bus.sel = sel_q[0];
    m0_bus.cti = cti_q[0]; m0_bus.bte = bte_q[0];
    m1_bus.cyc = cyc_q[1]; m1_bus.stb = stb_q[1]; m1_bus.we = we_q[1];
    m1_bus.adr = adr_q[1]; m1_bus.dat_w = dat_q[1]; m1_bus.sel = sel_q[1];
    m1_bus.cti = cti_q[1]; m1_bus.bte = bte_q[1];
    s0_bus.ack = s_ack; s0_bus.err = s_err; s0_bus.dat_r = s_dat;
  endtask

  task automatic compare_all();
    logic        e_cyc, e_stb, e_we, wd;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    logic [2:0]  e_cti;
    logic [1:0]  e_bte;
    e_cyc = 0; e_stb = 0; e_we = 0; e_adr = 0; e_dat = 0; e_sel = 0; e_cti = 0; e_bte = 0;
    wd = 0;
    if (own >= 0) begin
      e_cyc = cyc_q[own]; e_stb = stb_q[own]; e_we = we_q[own];
      e_adr = adr_q[own]; e_dat = dat_q[own]; e_sel = sel_q[own];
      e_cti = cti_q[own]; e_bte = bte_q[own];
      wd = stb_q[own] && !s_ack && !s_err && (run + 1 == c_TIMEOUT);
    end
    check("s0_cyc", 64'(s0_bus.cyc), 64'(e_cyc));
    check("s0_stb", 64'(s0_bus.stb), 64'(e_stb));
    check("s0_we", 64'(s0_bus.we), 64'(e_we));
    check("s0_adr", 64'(s0_bus.adr), 64'(e_adr));
    check("s0_dat_w", 64'(s0_bus.dat_w), 64'(e_dat));
    check("s0_sel", 64'(s0_bus.sel), 64'(e_sel));
    check("s0_cti", 64'(s0_bus.cti), 64'(e_cti));
    check("s0_bte", 64'(s0_bus.bte), 64'(e_bte));
    check("m0_ack", 64'(m0_bus.ack), 64'(s_ack && own == 0));
    check("m1_ack", 64'(m1_bus.ack), 64'(s_ack && own == 1));
    check("m0_err", 64'(m0_bus.err), 64'((s_err || wd) && own == 0));
    check("m1_err", 64'(m1_bus.err), 64'((s_err || wd) && own == 1));
    check("m0_dat_r", 64'(m0_bus.dat_r), 64'(s_dat));
    check("m1_dat_r", 64'(m1_bus.dat_r), 64'(s_dat));
  endtask

  // Least-recently-served wins a tie; an owner keeps the bus while its CYC stays high.
  task automatic model_edge();
    bit stalled;
    int nxt;
    if (!rstn) begin
      own = -1; last = 1; run = 0;
      return;
    end
    stalled = (own >= 0) && stb_q[own] && !s_ack && !s_err;
    if (!stalled || run + 1 == c_TIMEOUT) run = 0;
    else run++;
    if (own >= 0 && cyc_q[own]) nxt = own;
    else if (cyc_q[0] && cyc_q[1]) nxt = 1 - last;
    else if (cyc_q[0]) nxt = 0;
    else if (cyc_q[1]) nxt = 1;
    else nxt = -1;
    if (nxt != own) run = 0;
    if (nxt >= 0) last = nxt;
    own = nxt;
  endtask

  task automatic pre();
    drive();
    #1;
    compare_all();
  endtask

  task automatic post();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    cyc_q[n] = cyc; stb_q[n] = stb; we_q[n] = we;
    adr_q[n] = adr; dat_q[n] = dat; sel_q[n] = 4'hF; cti_q[n] = 3'b000; bte_q[n] = 2'b00;
  endtask

  task automatic go_idle(input int n_cycles);
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    s_ack = 0; s_err = 0;
    repeat (n_cycles) cycle();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    own = -1; last = 1; run = 0;
    rstn = 1'b0;
    s_ack = 0; s_err = 0; s_dat = 32'h1234_5678;
    set_m(0, 1, 1, 0, 32'hA000_0000, 32'h1111_1111);
    set_m(1, 1, 1, 1, 32'hB000_0000, 32'h2222_2222);
    drive();
    @(negedge clk);

    // Reset held with both masters requesting.
    repeat (3) begin
      pre();
      check("rst_s0_cyc", 64'(s0_bus.cyc), 64'd0);
      check("rst_m1_ack", 64'(m1_bus.ack), 64'd0);
      post();
    end
    rstn = 1'b1;
    pre();
    post();
    pre();
    check("first_gnt_m0", 64'(s0_bus.adr), 64'hA000_0000);
    post();
    go_idle(2);

    // Single master write from m1.
    set_m(1, 1, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF);
    pre();
    check("single_lat_cyc", 64'(s0_bus.cyc), 64'd0);
    post();
    s_ack = 1;
    pre();
    check("single_adr", 64'(s0_bus.adr), 64'h100);
    check("single_dat", 64'(s0_bus.dat_w), 64'hDEAD_BEEF);
    check("single_m1_ack", 64'(m1_bus.ack), 64'd1);
    check("single_m0_ack", 64'(m0_bus.ack), 64'd0);
    post();
    go_idle(2);

    // Lock: m0 holds CYC over 10 acked transfers while m1 keeps requesting.
    set_m(0, 1, 1, 0, 32'hC000_0000, 32'h3333_3333);
    cycle();
    set_m(1, 1, 1, 1, 32'hD000_0000, 32'h4444_4444);
    s_ack = 1;
    for (int i = 0; i < 10; i++) begin
      adr_q[0] = 32'hC000_0000 + 32'(i * 4);
      pre();
      check("lock_owner", 64'(s0_bus.adr), 64'(32'hC000_0000 + 32'(i * 4)));
      check("lock_m1_ack", 64'(m1_bus.ack), 64'd0);
      post();
    end
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    s_ack = 0;
    cycle();
    pre();
    check("lock_handover", 64'(s0_bus.adr), 64'hD000_0000);
    post();
    go_idle(2);

    // Watchdog: slave never answers, ERR in the 8th stalled cycle only.
    set_m(0, 1, 1, 0, 32'hE000_0000, 32'h5555_5555);
    cycle();
    for (int i = 1; i <= 8; i++) begin
      pre();
      check($sformatf("wd_err_c%0d", i), 64'(m0_bus.err), 64'(i == 8));
      check("wd_s0_stb", 64'(s0_bus.stb), 64'd1);
      post();
    end
    go_idle(2);
    set_m(0, 1, 1, 0, 32'hE000_0040, 32'h6666_6666);
    cycle();
    for (int i = 1; i <= 8; i++) begin
      s_ack = (i == 8);
      pre();
      check($sformatf("wd_ack_err_c%0d", i), 64'(m0_bus.err), 64'd0);
      if (i == 8) check("wd_ack_c8", 64'(m0_bus.ack), 64'd1);
      post();
    end
    go_idle(2);

    // Mid-transfer asynchronous reset during an m1 burst.
    set_m(1, 1, 1, 1, 32'hF000_0000, 32'h7777_7777);
    cti_q[1] = 3'b010;
    cycle();
    s_ack = 1;
    cycle();
    drive();
    #1;
    compare_all();
    #2;
    rstn = 1'b0;
    #1;
    own = -1; last = 1; run = 0;
    check("arst_s0_cyc", 64'(s0_bus.cyc), 64'd0);
    check("arst_m1_ack", 64'(m1_bus.ack), 64'd0);
    check("arst_s0_adr", 64'(s0_bus.adr), 64'd0);
    post();
    set_m(0, 1, 1, 0, 32'hA100_0000, 32'h8888_8888);
    s_ack = 0;
    cycle();
    rstn = 1'b1;
    cycle();
    pre();
    check("arst_first_m0", 64'(s0_bus.adr), 64'hA100_0000);
    post();
    go_idle(2);

    // Randomized traffic; every fourth block of 500 cycles has a silent slave.
    for (int i = 0; i < 4000; i++) begin
      bit quiet;
      int r;
      quiet = ((i / 500) % 4) == 3;
      for (int n = 0; n < 2; n++) begin
        if (cyc_q[n]) begin
          if ($urandom_range(0, 7) == 0) cyc_q[n] = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          cyc_q[n] = 1;
        end
        stb_q[n] = cyc_q[n] && ($urandom_range(0, 3) != 0);
        we_q[n]  = 1'($urandom);
        adr_q[n] = $urandom;
        dat_q[n] = $urandom;
        sel_q[n] = 4'($urandom);
        cti_q[n] = 3'($urandom);
        bte_q[n] = 2'($urandom);
      end
      r = $urandom_range(0, 19);
      s_ack = !quiet && (r < 7);
      s_err = !quiet && (r == 7);
      s_dat = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
